// File: rtl/uart_dump_pkg.sv
// Shared types and constants for the UART memory dumper.
package uart_dump_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    SEND,
    WAIT_TX,
    NEXT,
    FINISH
  } dump_state_t;

endpackage

// File: rtl/word_byte_serializer.sv
// Sends one loaded word as BYTE_W-bit chunks, MSB byte first, over a tx_en/tx_done handshake.
module word_byte_serializer
  import uart_dump_pkg::*;
#(
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [INSTR_WIDTH-1:0] word_in,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic [BYTE_W-1:0]      tx_data,
  output logic                   tx_en,
  output logic                   word_done
);

  localparam int BYTES = INSTR_WIDTH / BYTE_W;
  localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;

  dump_state_t            phase;
  dump_state_t            phase_next;
  logic [INSTR_WIDTH-1:0] shift_reg;
  logic [IDXW-1:0]        byte_idx;
  logic                   last_byte;

  assign last_byte = (byte_idx == IDXW'(BYTES - 1));
  // tx_done outside WAIT_TX is deliberately dropped.
  assign word_done = (phase == WAIT_TX) && tx_done && last_byte;

  always_ff @(posedge clk) begin
    if (rst) phase <= IDLE;
    else     phase <= phase_next;
  end

  always_comb begin
    phase_next = phase;
    case (phase)
      IDLE:    if (load) phase_next = SEND;
      SEND:    if (!tx_busy) phase_next = WAIT_TX;
      WAIT_TX: if (tx_done) phase_next = last_byte ? IDLE : SEND;
      default: phase_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      byte_idx  <= '0;
      tx_en     <= 1'b0;
      tx_data   <= '0;
    end else begin
      tx_en <= 1'b0;
      case (phase)
        IDLE: begin
          if (load) begin
            shift_reg <= word_in;
            byte_idx  <= '0;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_en   <= 1'b1;
            tx_data <= shift_reg[INSTR_WIDTH-1 -: BYTE_W];
          end
        end
        WAIT_TX: begin
          if (tx_done) begin
            shift_reg <= shift_reg << BYTE_W;
            if (!last_byte) byte_idx <= byte_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_mem_dumper.sv
// Reads a run of words from instruction memory and streams them out of the UART TX port.
module uart_mem_dumper
  import uart_dump_pkg::*;
#(
  parameter  int INSTR_WIDTH = 32,
  parameter  int DEPTH       = 256,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [AW-1:0]          start_addr,
  input  logic [AW:0]            word_count,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          mem_rd_addr,
  input  logic [INSTR_WIDTH-1:0] mem_rd_data,
  output logic [BYTE_W-1:0]      tx_data,
  output logic                   tx_en,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic [AW:0]            words_sent
);

  if ((INSTR_WIDTH % BYTE_W) != 0 || INSTR_WIDTH == 0) begin : g_width_check
    $error("INSTR_WIDTH must be a nonzero multiple of 8");
  end

  dump_state_t state;
  dump_state_t state_next;
  logic [AW:0] remaining;
  logic        load;
  logic        word_done;

  assign load = (state == LOAD);

  word_byte_serializer #(
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .word_in  (mem_rd_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_data  (tx_data),
    .tx_en    (tx_en),
    .word_done(word_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // SEND here spans the serializer's whole SEND/WAIT_TX byte loop for one word.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (word_count != '0) ? READ : FINISH;
      READ:    state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    if (word_done) state_next = NEXT;
      NEXT:    state_next = (remaining == (AW+1)'(1)) ? FINISH : READ;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_addr <= '0;
      remaining   <= '0;
      words_sent  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (word_count != '0) begin
              mem_rd_addr <= start_addr;
              remaining   <= word_count;
              words_sent  <= '0;
            end
          end
        end
        NEXT: begin
          words_sent  <= words_sent + 1'b1;
          remaining   <= remaining - 1'b1;
          mem_rd_addr <= (mem_rd_addr == AW'(DEPTH - 1)) ? '0 : mem_rd_addr + 1'b1;
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_dumper.sv
// Directed bench for uart_mem_dumper with a behavioural sync RAM and UART TX responder.
module tb_uart_mem_dumper;

  localparam int IW    = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   word_count;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_rd_addr;
  logic [IW-1:0] mem_rd_data;
  logic [7:0]    tx_data;
  logic          tx_en;
  logic          tx_busy;
  logic          tx_done;
  logic [AW:0]   words_sent;

  logic [IW-1:0] mem [DEPTH];
  logic          model_busy;
  logic          model_done;
  logic          hold_busy;
  logic          spur_done;
  int unsigned   tx_cnt;
  logic [7:0]    got [$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_mem_dumper #(
    .INSTR_WIDTH(IW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .words_sent (words_sent)
  );

  assign tx_busy = model_busy | hold_busy;
  assign tx_done = model_done | spur_done;

  always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

  // UART responder: busy for 10 cycles after each tx_en, then a one-cycle tx_done.
  always @(posedge clk) begin
    if (rst) begin
      model_busy <= 1'b0;
      model_done <= 1'b0;
      tx_cnt     <= 0;
    end else begin
      model_done <= 1'b0;
      if (tx_en) begin
        got.push_back(tx_data);
        model_busy <= 1'b1;
        tx_cnt     <= 10;
      end else if (tx_cnt != 0) begin
        tx_cnt <= tx_cnt - 1;
        if (tx_cnt == 1) begin
          model_done <= 1'b1;
          model_busy <= 1'b0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] a, input logic [AW:0] c);
    @(negedge clk);
    start_addr = a;
    word_count = c;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  task automatic compare_stream(input int unsigned addr0, input int unsigned count, input string tag);
    logic [IW-1:0] word;
    int unsigned   idx;
    check_eq({tag, "_nbytes"}, 64'(got.size()), 64'(count * 4));
    for (int unsigned w = 0; w < count; w++) begin
      word = mem[(addr0 + w) % DEPTH];
      for (int unsigned b = 0; b < 4; b++) begin
        idx = w * 4 + b;
        if (idx < got.size())
          check_eq($sformatf("%s_b%0d", tag, idx), 64'(got[idx]), 64'(word[31 - 8*b -: 8]));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en_seen;
    int seen;
    int n;

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;
    hold_busy  = 1'b0;
    spur_done  = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_busy",     64'(busy),        64'd0);
    check_eq("rst_done",     64'(done),        64'd0);
    check_eq("rst_tx_en",    64'(tx_en),       64'd0);
    check_eq("rst_tx_data",  64'(tx_data),     64'd0);
    check_eq("rst_rd_addr",  64'(mem_rd_addr), 64'd0);
    check_eq("rst_words",    64'(words_sent),  64'd0);
    rst = 1'b0;

    // Single word, latency and pulse shape.
    mem[0] = 32'hDEADBEEF;
    got.delete();
    pulse_start(8'd0, 9'd1);
    check_eq("t1_busy_c1", 64'(busy), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check_eq("t1_tx_en_c3", 64'(tx_en), 64'd0);
    @(negedge clk);
    check_eq("t1_tx_en_c4", 64'(tx_en), 64'd1);
    check_eq("t1_tx_data0", 64'(tx_data), 64'hDE);
    @(negedge clk);
    check_eq("t1_tx_en_c5", 64'(tx_en), 64'd0);
    wait_done(1000, "t1");
    check_eq("t1_words", 64'(words_sent), 64'd1);
    compare_stream(0, 1, "t1");
    check_eq("t1_b0_const", 64'(got[0]), 64'hDE);
    check_eq("t1_b3_const", 64'(got[3]), 64'hEF);
    @(negedge clk);
    check_eq("t1_done_pulse", 64'(done), 64'd0);
    check_eq("t1_busy_after", 64'(busy), 64'd0);

    // Three words across the address wrap.
    mem[254] = 32'h11223344;
    mem[255] = 32'h55667788;
    mem[0]   = 32'h99AABBCC;
    got.delete();
    pulse_start(8'd254, 9'd3);
    wait_done(2000, "t2");
    compare_stream(254, 3, "t2");
    check_eq("t2_first",   64'(got[0]),  64'h11);
    check_eq("t2_last",    64'(got[11]), 64'hCC);
    check_eq("t2_words",   64'(words_sent), 64'd3);
    check_eq("t2_rd_addr", 64'(mem_rd_addr), 64'd1);

    // Zero-length run.
    got.delete();
    pulse_start(8'd5, 9'd0);
    check_eq("t3_busy_c1", 64'(busy), 64'd1);
    check_eq("t3_done_c1", 64'(done), 64'd0);
    @(negedge clk);
    check_eq("t3_done_c2", 64'(done), 64'd1);
    check_eq("t3_busy_c2", 64'(busy), 64'd0);
    check_eq("t3_rd_addr", 64'(mem_rd_addr), 64'd1);
    repeat (5) @(negedge clk);
    check_eq("t3_no_tx", 64'(got.size()), 64'd0);

    // tx_busy held at first SEND, plus an ignored start mid-run.
    mem[1] = 32'h01020304;
    got.delete();
    hold_busy = 1'b1;
    pulse_start(8'd0, 9'd2);
    en_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 20) begin
        start_addr = 8'd100;
        word_count = 9'd5;
      end
      start = (i == 20);
      if (tx_en) en_seen++;
    end
    start = 1'b0;
    check_eq("t4_en_while_busy", 64'(en_seen), 64'd0);
    hold_busy = 1'b0;
    @(negedge clk);
    check_eq("t4_en_release", 64'(tx_en), 64'd1);
    @(negedge clk);
    check_eq("t4_en_single", 64'(tx_en), 64'd0);
    wait_done(2000, "t4");
    compare_stream(0, 2, "t4");
    check_eq("t4_words", 64'(words_sent), 64'd2);

    // Reset after the second tx_done of word 0.
    got.delete();
    pulse_start(8'd0, 9'd1);
    seen = 0;
    n    = 0;
    while (seen < 2 && n < 1000) begin
      @(negedge clk);
      n++;
      if (tx_done) seen++;
    end
    check_eq("t5_two_bytes", 64'(seen), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_busy",  64'(busy),       64'd0);
    check_eq("t5_rst_tx_en", 64'(tx_en),      64'd0);
    check_eq("t5_rst_words", 64'(words_sent), 64'd0);
    rst = 1'b0;
    got.delete();
    pulse_start(8'd0, 9'd1);
    wait_done(1000, "t5");
    compare_stream(0, 1, "t5");
    check_eq("t5_restart_b0", 64'(got[0]), 64'h99);

    // Spurious tx_done during READ and LOAD.
    got.delete();
    pulse_start(8'd254, 9'd2);
    spur_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    spur_done = 1'b0;
    wait_done(2000, "t6");
    compare_stream(254, 2, "t6");
    check_eq("t6_words", 64'(words_sent), 64'd2);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
